banco_registradores_param: RTL and testbench

Parametrised general-purpose and boolean register bank for the nRISC datapath, the successor to the fixed 8×8 bank. It has the following features:
- two read ports and one write port on the general bank;
- two read ports and one write port on the boolean flag bank;
- same-cycle write-to-read forwarding;
- a pending-write scoreboard that the decode stage uses for hazard detection;
- freezing under `Halt`.

It sits between decode (reads, reservations) and writeback (writes).

---
 rtl/banco_registradores_param_pkg.sv | 10 +
 rtl/banco_registradores_param_if.sv | 45 ++++
 rtl/banco_registradores_param_placar.sv | 40 ++++
 rtl/banco_registradores_param.sv | 83 ++++++++
 tb/tb_banco_registradores_param.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/banco_registradores_param_pkg.sv
// Shared nRISC constants and address type used by decode, writeback and the register bank.
package nrisc_pkg;

    localparam int NRISC_NUM_REGS = 8;
    localparam int NRISC_LARGURA  = 8;
    localparam int NRISC_NUM_BOOL = 4;

    typedef logic [$clog2(NRISC_NUM_REGS)-1:0] reg_addr_t;

endpackage

// File: rtl/banco_registradores_param_if.sv
// Decode/writeback-side bus of the register bank: reads, writes, reservations and pending flags.
interface banco_registradores_param_if
    import nrisc_pkg::*;
#(
    parameter int NUM_REGS = NRISC_NUM_REGS,
    parameter int LARGURA  = NRISC_LARGURA,
    parameter int NUM_BOOL = NRISC_NUM_BOOL
);
    localparam int RA = $clog2(NUM_REGS);
    localparam int BA = $clog2(NUM_BOOL);

    logic [RA-1:0]      RegLido1;
    logic [RA-1:0]      RegLido2;
    logic [LARGURA-1:0] Dado1;
    logic [LARGURA-1:0] Dado2;
    logic               EscreveReg;
    logic [RA-1:0]      RegEscrito;
    logic [LARGURA-1:0] DadoEscrito;
    logic [BA-1:0]      BoolLido1;
    logic [BA-1:0]      BoolLido2;
    logic               DadoBool1;
    logic               DadoBool2;
    logic               EscreveBool;
    logic [BA-1:0]      BoolEscrito;
    logic               DadoBoolEscrito;
    logic               Reserva;
    logic [RA-1:0]      RegReservado;
    logic               Pendente1;
    logic               Pendente2;

    modport master (
        output RegLido1, RegLido2, EscreveReg, RegEscrito, DadoEscrito,
               BoolLido1, BoolLido2, EscreveBool, BoolEscrito, DadoBoolEscrito,
               Reserva, RegReservado,
        input  Dado1, Dado2, DadoBool1, DadoBool2, Pendente1, Pendente2
    );

    modport slave (
        input  RegLido1, RegLido2, EscreveReg, RegEscrito, DadoEscrito,
               BoolLido1, BoolLido2, EscreveBool, BoolEscrito, DadoBoolEscrito,
               Reserva, RegReservado,
        output Dado1, Dado2, DadoBool1, DadoBool2, Pendente1, Pendente2
    );

endinterface

// File: rtl/banco_registradores_param_placar.sv
// Pending-write scoreboard: one bit per general register, set by reservations, cleared by writes.
module placar_pendencias
    import nrisc_pkg::*;
#(
    parameter int NUM_REGS  = NRISC_NUM_REGS,
    parameter bit ZERO_FIXO = 1'b1,
    localparam int RA       = $clog2(NUM_REGS)
) (
    input  logic          Clock,
    input  logic          Reset_n,
    input  logic          rs,
    input  logic          wr,
    input  logic [RA-1:0] RegReservado,
    input  logic [RA-1:0] RegEscrito,
    input  logic [RA-1:0] RegLido1,
    input  logic [RA-1:0] RegLido2,
    output logic          Pendente1,
    output logic          Pendente2
);

    logic [NUM_REGS-1:0] pend;

    // The set is assigned after the clear so a same-register reservation wins.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pend <= '0;
        end else begin
            if (wr) pend[RegEscrito]   <= 1'b0;
            if (rs) pend[RegReservado] <= 1'b1;
        end
    end

    always_comb begin
        Pendente1 = pend[RegLido1] & ~(wr && RegEscrito == RegLido1)
                    & ~(ZERO_FIXO && RegLido1 == '0);
        Pendente2 = pend[RegLido2] & ~(wr && RegEscrito == RegLido2)
                    & ~(ZERO_FIXO && RegLido2 == '0);
    end

endmodule

// File: rtl/banco_registradores_param.sv
// Parametrised general and boolean register bank with write forwarding, pending scoreboard and Halt freeze.
module banco_registradores_param
    import nrisc_pkg::*;
#(
    parameter int NUM_REGS  = NRISC_NUM_REGS,
    parameter int LARGURA   = NRISC_LARGURA,
    parameter int NUM_BOOL  = NRISC_NUM_BOOL,
    parameter bit ZERO_FIXO = 1'b1
) (
    input  logic                        Clock,
    input  logic                        Reset_n,
    input  logic                        Halt,
    banco_registradores_param_if.slave  bus
);

    logic [LARGURA-1:0] banco [NUM_REGS];
    logic               bools [NUM_BOOL];

    logic wr, bw, rs;
    logic fwdReg, fwdBool;

    assign wr = bus.EscreveReg & ~Halt & ~(ZERO_FIXO && bus.RegEscrito == '0);
    assign bw = bus.EscreveBool & ~Halt;
    assign rs = bus.Reserva & ~Halt & ~(ZERO_FIXO && bus.RegReservado == '0);

    // Forwarding is masked during reset so reads are 0 while storage is held clear.
    assign fwdReg  = wr & Reset_n;
    assign fwdBool = bw & Reset_n;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) banco[i] <= '0;
        end else if (wr) begin
            banco[bus.RegEscrito] <= bus.DadoEscrito;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < NUM_BOOL; i++) bools[i] <= 1'b0;
        end else if (bw) begin
            bools[bus.BoolEscrito] <= bus.DadoBoolEscrito;
        end
    end

    always_comb begin
        if (ZERO_FIXO && bus.RegLido1 == '0)
            bus.Dado1 = '0;
        else if (fwdReg && bus.RegEscrito == bus.RegLido1)
            bus.Dado1 = bus.DadoEscrito;
        else
            bus.Dado1 = banco[bus.RegLido1];

        if (ZERO_FIXO && bus.RegLido2 == '0)
            bus.Dado2 = '0;
        else if (fwdReg && bus.RegEscrito == bus.RegLido2)
            bus.Dado2 = bus.DadoEscrito;
        else
            bus.Dado2 = banco[bus.RegLido2];

        bus.DadoBool1 = (fwdBool && bus.BoolEscrito == bus.BoolLido1)
                        ? bus.DadoBoolEscrito : bools[bus.BoolLido1];
        bus.DadoBool2 = (fwdBool && bus.BoolEscrito == bus.BoolLido2)
                        ? bus.DadoBoolEscrito : bools[bus.BoolLido2];
    end

    placar_pendencias #(
        .NUM_REGS  (NUM_REGS),
        .ZERO_FIXO (ZERO_FIXO)
    ) placar (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .rs           (rs),
        .wr           (wr),
        .RegReservado (bus.RegReservado),
        .RegEscrito   (bus.RegEscrito),
        .RegLido1     (bus.RegLido1),
        .RegLido2     (bus.RegLido2),
        .Pendente1    (bus.Pendente1),
        .Pendente2    (bus.Pendente2)
    );

endmodule

// File: tb/tb_banco_registradores_param.sv
// Scoreboard bench for banco_registradores_param: expectations from a reference model, checked each negedge.
module tb_banco_registradores_param;

    logic Clock = 1'b1;
    logic Reset_n;
    logic Halt;

    always #5 Clock = ~Clock;

    banco_registradores_param_if #(.NUM_REGS(8), .LARGURA(8), .NUM_BOOL(4)) bus ();

    banco_registradores_param #(
        .NUM_REGS  (8),
        .LARGURA   (8),
        .NUM_BOOL  (4),
        .ZERO_FIXO (1'b1)
    ) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Halt    (Halt),
        .bus     (bus)
    );

    typedef struct {
        logic       rstn;
        logic       halt;
        logic [2:0] rl1, rl2;
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic [1:0] bl1, bl2;
        logic       bwe;
        logic [1:0] ba;
        logic       bd;
        logic       rsv;
        logic [2:0] ra;
    } stim_t;

    typedef struct {
        string      tag;
        int         kind;
        logic [7:0] exp;
    } exp_t;

    exp_t expQ[$];

    logic [7:0] mBanco [8];
    logic       mBool  [4];
    logic       mPend  [8];

    int errors = 0;
    int checks = 0;

    task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    function automatic logic wrEff(input stim_t s);
        return s.we && !s.halt && s.wa != 3'd0;
    endfunction

    function automatic logic bwEff(input stim_t s);
        return s.bwe && !s.halt;
    endfunction

    function automatic logic rsEff(input stim_t s);
        return s.rsv && !s.halt && s.ra != 3'd0;
    endfunction

    function automatic logic [7:0] expDado(input stim_t s, input logic [2:0] a);
        if (a == 3'd0) return 8'h00;
        if (s.rstn && wrEff(s) && s.wa == a) return s.wd;
        return mBanco[a];
    endfunction

    function automatic logic [7:0] expBool(input stim_t s, input logic [1:0] a);
        if (s.rstn && bwEff(s) && s.ba == a) return {7'd0, s.bd};
        return {7'd0, mBool[a]};
    endfunction

    function automatic logic [7:0] expPend(input stim_t s, input logic [2:0] a);
        if (a == 3'd0) return 8'h00;
        return {7'd0, mPend[a] && !(wrEff(s) && s.wa == a)};
    endfunction

    function automatic stim_t idle(input logic [2:0] r1, input logic [2:0] r2);
        stim_t s;
        s = '{rstn: 1'b1, halt: 1'b0, rl1: r1, rl2: r2, we: 1'b0, wa: 3'd0, wd: 8'h00,
              bl1: 2'd0, bl2: 2'd0, bwe: 1'b0, ba: 2'd0, bd: 1'b0, rsv: 1'b0, ra: 3'd0};
        return s;
    endfunction

    task automatic step(input string tag, input stim_t s);
        Reset_n                 = s.rstn;
        Halt                    = s.halt;
        bus.RegLido1            = s.rl1;
        bus.RegLido2            = s.rl2;
        bus.EscreveReg          = s.we;
        bus.RegEscrito          = s.wa;
        bus.DadoEscrito         = s.wd;
        bus.BoolLido1           = s.bl1;
        bus.BoolLido2           = s.bl2;
        bus.EscreveBool         = s.bwe;
        bus.BoolEscrito         = s.ba;
        bus.DadoBoolEscrito     = s.bd;
        bus.Reserva             = s.rsv;
        bus.RegReservado        = s.ra;
        if (!s.rstn) begin
            for (int i = 0; i < 8; i++) begin mBanco[i] = 8'h00; mPend[i] = 1'b0; end
            for (int i = 0; i < 4; i++) mBool[i] = 1'b0;
        end
        expQ.push_back('{tag, 0, expDado(s, s.rl1)});
        expQ.push_back('{tag, 1, expDado(s, s.rl2)});
        expQ.push_back('{tag, 2, expBool(s, s.bl1)});
        expQ.push_back('{tag, 3, expBool(s, s.bl2)});
        expQ.push_back('{tag, 4, expPend(s, s.rl1)});
        expQ.push_back('{tag, 5, expPend(s, s.rl2)});
        @(posedge Clock);
        if (s.rstn) begin
            if (wrEff(s)) begin mBanco[s.wa] = s.wd; mPend[s.wa] = 1'b0; end
            if (bwEff(s)) mBool[s.ba] = s.bd;
            if (rsEff(s)) mPend[s.ra] = 1'b1;
        end
        #1;
    endtask

    string kindName [6] = '{"Dado1", "Dado2", "DadoBool1", "DadoBool2", "Pendente1", "Pendente2"};

    always @(negedge Clock) begin
        exp_t e;
        logic [7:0] obs;
        while (expQ.size() != 0) begin
            e = expQ.pop_front();
            case (e.kind)
                0:       obs = bus.Dado1;
                1:       obs = bus.Dado2;
                2:       obs = {7'd0, bus.DadoBool1};
                3:       obs = {7'd0, bus.DadoBool2};
                4:       obs = {7'd0, bus.Pendente1};
                default: obs = {7'd0, bus.Pendente2};
            endcase
            checkVal($sformatf("%s/%s", e.tag, kindName[e.kind]), obs, e.exp);
        end
    end

    initial begin
        stim_t s;
        #1;
        s = idle(3'd3, 3'd5); s.rstn = 1'b0;
        step("reset", s);

        s = idle(3'd5, 3'd5); s.we = 1'b1; s.wa = 3'd5; s.wd = 8'h3C;
        step("wr_r5_fwd", s);
        step("wr_r5_stored", idle(3'd5, 3'd0));

        s = idle(3'd0, 3'd0); s.we = 1'b1; s.wa = 3'd0; s.wd = 8'hAA;
        step("wr_r0", s);
        step("rd_r0", idle(3'd0, 3'd0));

        s = idle(3'd1, 3'd2); s.rsv = 1'b1; s.ra = 3'd2;
        step("rsv_r2", s);
        step("pend_c2", idle(3'd1, 3'd2));
        step("pend_c3", idle(3'd1, 3'd2));
        step("pend_c4", idle(3'd1, 3'd2));
        s = idle(3'd1, 3'd2); s.we = 1'b1; s.wa = 3'd2; s.wd = 8'h11;
        step("wr_r2", s);
        step("r2_after", idle(3'd2, 3'd2));

        s = idle(3'd6, 3'd6); s.rsv = 1'b1; s.ra = 3'd6;
        step("rsv_r6", s);
        s = idle(3'd6, 3'd6); s.rsv = 1'b1; s.ra = 3'd6; s.we = 1'b1; s.wa = 3'd6; s.wd = 8'h66;
        step("setprio_r6", s);
        step("setprio_after", idle(3'd6, 3'd6));

        s = idle(3'd1, 3'd1); s.halt = 1'b1; s.we = 1'b1; s.wa = 3'd1; s.wd = 8'hFF;
        s.bwe = 1'b1; s.ba = 2'd2; s.bd = 1'b1; s.bl1 = 2'd2; s.bl2 = 2'd2;
        s.rsv = 1'b1; s.ra = 3'd1;
        step("halt", s);
        s = idle(3'd1, 3'd1); s.bl1 = 2'd2; s.bl2 = 2'd2;
        step("halt_after", s);

        s = idle(3'd0, 3'd0); s.bwe = 1'b1; s.ba = 2'd3; s.bd = 1'b1; s.bl1 = 2'd3; s.bl2 = 2'd3;
        step("b3_set", s);
        s.bd = 1'b0;
        step("b3_clr", s);
        s = idle(3'd0, 3'd0); s.bl1 = 2'd3; s.bl2 = 2'd3;
        step("b3_after", s);

        s = idle(3'd3, 3'd4); s.we = 1'b1; s.wa = 3'd3; s.wd = 8'hA5;
        step("wr_r3", s);
        s = idle(3'd3, 3'd4); s.rsv = 1'b1; s.ra = 3'd3;
        step("rsv_r3", s);
        s = idle(3'd3, 3'd4); s.rstn = 1'b0;
        step("async_reset", s);
        step("post_reset", idle(3'd3, 3'd4));

        for (int i = 0; i < 200; i++) begin
            s.rstn = 1'b1;
            s.halt = ($urandom_range(0, 7) == 0);
            s.rl1  = 3'($urandom_range(0, 7));
            s.rl2  = 3'($urandom_range(0, 7));
            s.we   = 1'($urandom_range(0, 1));
            s.wa   = 3'($urandom_range(0, 7));
            s.wd   = 8'($urandom_range(0, 255));
            s.bl1  = 2'($urandom_range(0, 3));
            s.bl2  = 2'($urandom_range(0, 3));
            s.bwe  = 1'($urandom_range(0, 1));
            s.ba   = 2'($urandom_range(0, 3));
            s.bd   = 1'($urandom_range(0, 1));
            s.rsv  = 1'($urandom_range(0, 1));
            s.ra   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) s.wa = s.rl1;
            step($sformatf("rand%0d", i), s);
        end

        @(negedge Clock);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
